// File: rtl/keypad_pulse_gen.sv
// Keypad front end: synchronises and debounces 12 raw key lines and emits one pulse per accepted press.
// Latency: a key clean from edge E1 pulses after edge E(DEB_CYCLES+3) (2 sync + 1 capture + DEB_CYCLES count).
// Backpressure: none; pulses are fire-and-forget, and chords, holds and bounces are absorbed here.
//
// Ports:
//   CLK       in   1   system clock, rising edge
//   RESETN    in   1   asynchronous active-low reset
//   KEY_RAW   in   12  raw key lines, active high: [9:0]=digits 0-9, [10]=*, [11]=#
//   BUTTON    out  10  one-cycle one-hot digit pulse
//   STAR      out  1   one-cycle * pulse
//   HASH      out  1   one-cycle # pulse
//   KEY_CODE  out  4   code of last accepted key (0-9, 10=*, 11=#), held until next accept
//   BUSY      out  1   high whenever the FSM is not IDLE
module keypad_pulse_gen #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 20
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [11:0] KEY_RAW,
  output logic [9:0]  BUTTON,
  output logic        STAR,
  output logic        HASH,
  output logic [3:0]  KEY_CODE,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [11:0]      key_meta;
  logic [11:0]      key_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [11:0]      capture;
  logic [11:0]      capture_nxt;
  logic [11:0]      pulse_nxt;
  logic [3:0]       code_nxt;
  logic             key_one_hot;

  function automatic logic [3:0] encode(input logic [11:0] v);
    logic [3:0] code;
    code = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (v[i]) code = 4'(i);
    end
    return code;
  endfunction

  // Two-flop synchroniser; nothing downstream looks at KEY_RAW directly.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      key_meta <= '0;
      key_s    <= '0;
    end else begin
      key_meta <= KEY_RAW;
      key_s    <= key_meta;
    end
  end

  // Exactly one bit set: chords must never be captured.
  assign key_one_hot = (key_s != 12'd0) && ((key_s & (key_s - 12'd1)) == 12'd0);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    capture_nxt = capture;
    pulse_nxt   = '0;
    code_nxt    = KEY_CODE;
    case (state)
      IDLE: begin
        if (key_s != 12'd0) begin
          if (key_one_hot) begin
            capture_nxt = key_s;
            cnt_nxt     = '0;
            state_nxt   = PRESS_DB;
          end else begin
            // Chord: park in HELD so nothing fires until everything is released.
            state_nxt = HELD;
          end
        end
      end
      PRESS_DB: begin
        if (key_s != capture) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt == DEB_LAST) begin
          pulse_nxt = capture;
          code_nxt  = encode(capture);
          state_nxt = HELD;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (key_s == 12'd0) begin
          cnt_nxt   = '0;
          state_nxt = REL_DB;
        end
      end
      REL_DB: begin
        // Any key activity during release debounce is treated as still held,
        // so a release glitch can never produce a second pulse.
        if (key_s != 12'd0) begin
          state_nxt = HELD;
        end else if (cnt == DEB_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state    <= IDLE;
      cnt      <= '0;
      capture  <= '0;
      BUTTON   <= '0;
      STAR     <= 1'b0;
      HASH     <= 1'b0;
      KEY_CODE <= 4'd0;
      BUSY     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      capture  <= capture_nxt;
      BUTTON   <= pulse_nxt[9:0];
      STAR     <= pulse_nxt[10];
      HASH     <= pulse_nxt[11];
      KEY_CODE <= code_nxt;
      BUSY     <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_keypad_pulse_gen.sv
// Directed bench for keypad_pulse_gen with DEB_CYCLES=4: latency, bounce, chord, release glitch,
// reset mid-debounce and a key stream. Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, so "edge e" means the e-th rising edge after the change.
module tb_keypad_pulse_gen;

  logic        CLK;
  logic        RESETN;
  logic [11:0] KEY_RAW;
  logic [9:0]  BUTTON;
  logic        STAR;
  logic        HASH;
  logic [3:0]  KEY_CODE;
  logic        BUSY;

  int errors = 0;
  int checks = 0;
  int total_pulses = 0;
  int onehot_bad = 0;
  int wide_bad = 0;
  logic [11:0] prev_pulse = '0;

  keypad_pulse_gen #(.DEB_CYCLES(4), .CNT_W(20)) dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .KEY_RAW  (KEY_RAW),
    .BUTTON   (BUTTON),
    .STAR     (STAR),
    .HASH     (HASH),
    .KEY_CODE (KEY_CODE),
    .BUSY     (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Check the pulse vector after each of `edges` edges; only `pulse_edge` may show `pat`.
  task automatic watch(input string tag, input int edges, input int pulse_edge, input logic [11:0] pat);
    logic [11:0] exp;
    for (int e = 1; e <= edges; e++) begin
      @(posedge CLK);
      #1;
      exp = (e == pulse_edge) ? pat : 12'd0;
      check($sformatf("%s e%0d", tag, e), {20'd0, HASH, STAR, BUTTON}, {20'd0, exp});
    end
  endtask

  // Every-cycle monitor: one-hot across the pulse outputs, pulse width, pulse total.
  always @(negedge CLK) begin
    logic [11:0] pv;
    if (RESETN) begin
      pv = {HASH, STAR, BUTTON};
      if ($countones(pv) > 1) onehot_bad++;
      if (pv != 12'd0 && prev_pulse != 12'd0) wide_bad++;
      if (pv != 12'd0) total_pulses++;
      prev_pulse = pv;
    end
  end

  logic [11:0] stream_keys [3] = '{12'h002, 12'h004, 12'h800};
  logic [3:0]  stream_codes[3] = '{4'd1, 4'd2, 4'd11};

  initial begin
    RESETN  = 1'b0;
    KEY_RAW = 12'd0;
    step(3);
    check("rst button", {22'd0, BUTTON}, 32'd0);
    check("rst star_hash", {30'd0, STAR, HASH}, 32'd0);
    check("rst code", {28'd0, KEY_CODE}, 32'd0);
    check("rst busy", {31'd0, BUSY}, 32'd0);
    RESETN = 1'b1;
    step(3);

    // T1: clean press of 7, pulse after E7, no repeat while held.
    KEY_RAW = 12'h080;
    watch("t1", 8, 7, 12'h080);
    check("t1 code", {28'd0, KEY_CODE}, 32'd7);
    check("t1 busy", {31'd0, BUSY}, 32'd1);
    step(100);
    check("t1 no repeat", total_pulses, 1);
    KEY_RAW = 12'd0;
    step(10);
    check("t1 idle busy", {31'd0, BUSY}, 32'd0);

    // T2: bounce on key 3, then stable.
    for (int i = 0; i < 4; i++) begin
      KEY_RAW = (i % 2 == 0) ? 12'h008 : 12'h000;
      step(1);
    end
    KEY_RAW = 12'h008;
    watch("t2", 9, 7, 12'h008);
    check("t2 count", total_pulses, 2);
    check("t2 code", {28'd0, KEY_CODE}, 32'd3);
    KEY_RAW = 12'd0;
    step(10);

    // T3: chord rejected, BUSY while held; then * accepted.
    KEY_RAW = 12'h003;
    step(20);
    check("t3 chord busy", {31'd0, BUSY}, 32'd1);
    check("t3 chord nopulse", total_pulses, 2);
    KEY_RAW = 12'd0;
    step(10);
    check("t3 chord released", {31'd0, BUSY}, 32'd0);
    KEY_RAW = 12'h400;
    watch("t3 star", 8, 7, 12'h400);
    check("t3 code", {28'd0, KEY_CODE}, 32'd10);
    KEY_RAW = 12'd0;
    step(10);

    // T4: # with a 2-cycle release glitch, then a re-press before rearm.
    KEY_RAW = 12'h800;
    watch("t4 hash", 8, 7, 12'h800);
    step(5);
    KEY_RAW = 12'd0;
    step(2);
    KEY_RAW = 12'h800;
    watch("t4 glitch", 20, 0, 12'h000);
    check("t4 one hash", total_pulses, 4);
    KEY_RAW = 12'd0;
    step(3);
    KEY_RAW = 12'h800;
    watch("t4 early", 20, 0, 12'h000);
    check("t4 early busy", {31'd0, BUSY}, 32'd1);
    KEY_RAW = 12'd0;
    step(10);
    check("t4 idle", {31'd0, BUSY}, 32'd0);

    // T5: reset while in PRESS_DB with cnt=2, key kept held.
    KEY_RAW = 12'h020;
    step(5);
    check("t5 pre busy", {31'd0, BUSY}, 32'd1);
    RESETN = 1'b0;
    #1;
    check("t5 async busy", {31'd0, BUSY}, 32'd0);
    check("t5 async code", {28'd0, KEY_CODE}, 32'd0);
    check("t5 async pulses", {20'd0, HASH, STAR, BUTTON}, 32'd0);
    @(posedge CLK);
    #1;
    RESETN = 1'b1;
    watch("t5 after", 8, 7, 12'h020);
    check("t5 code", {28'd0, KEY_CODE}, 32'd5);
    KEY_RAW = 12'd0;
    step(10);

    // T6: stream 1, 2, #.
    for (int k = 0; k < 3; k++) begin
      KEY_RAW = stream_keys[k];
      watch($sformatf("t6 key%0d", k), 8, 7, stream_keys[k]);
      check($sformatf("t6 code%0d", k), {28'd0, KEY_CODE}, {28'd0, stream_codes[k]});
      KEY_RAW = 12'd0;
      step(10);
    end

    check("total pulses", total_pulses, 8);
    check("onehot every cycle", onehot_bad, 0);
    check("pulse width", wide_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
